// File: rtl/sram_fifo_arbiter_if.sv
// Requester and SRAM FIFO controller signals of the arbiter, grouped as one bundle.
// The arbiter connects through the slave modport; the requesters/controller side uses master.
interface sram_fifo_arbiter_if;
    logic [3:0]  req;
    logic [15:0] slave_wdata;
    logic [15:0] master_wdata;
    logic [3:0]  ack;
    logic        resp_err;
    logic [15:0] slave_rdata;
    logic [15:0] master_rdata;
    logic        mem_req;
    logic [1:0]  mem_op;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        fifo_i_full;
    logic        fifo_i_empty;
    logic        fifo_o_full;
    logic        fifo_o_empty;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  req, slave_wdata, master_wdata, mem_done, mem_rdata,
               fifo_i_full, fifo_i_empty, fifo_o_full, fifo_o_empty,
        output ack, resp_err, slave_rdata, master_rdata, mem_req, mem_op,
               mem_wdata, busy, err_timeout
    );

    modport master (
        output req, slave_wdata, master_wdata, mem_done, mem_rdata,
               fifo_i_full, fifo_i_empty, fifo_o_full, fifo_o_empty,
        input  ack, resp_err, slave_rdata, master_rdata, mem_req, mem_op,
               mem_wdata, busy, err_timeout
    );
endinterface

// File: rtl/sram_fifo_arbiter.sv
// Round-robin arbiter sharing one SRAM dual-FIFO controller among the SPI slave/master
// push/pop requesters; one command in flight, bounded by a timeout, with flag settle gap.
module sram_fifo_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned FLAG_SETTLE    = 2
) (
    input logic          clk,
    input logic          rst,
    sram_fifo_arbiter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_SETTLE} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] LP_SETTLE  = 8'(FLAG_SETTLE);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_g, w_g_nxt;
    logic [1:0]  r_rr, w_rr_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_ack, w_ack_nxt;
    logic        r_resp_err, w_resp_err_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic [1:0]  r_mem_op, w_mem_op_nxt;
    logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [15:0] r_srd, w_srd_nxt;
    logic [15:0] r_mrd, w_mrd_nxt;
    logic        r_err_to, w_err_to_nxt;

    logic [3:0]  w_elig;
    logic        w_found;
    logic [1:0]  w_pick;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    assign w_elig    = bus.req & {~bus.fifo_i_empty, ~bus.fifo_o_full,
                                  ~bus.fifo_o_empty, ~bus.fifo_i_full};
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == LP_TIMEOUT);

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!w_found && w_elig[r_rr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_rr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT:   if (bus.mem_done || w_timeout) w_state_nxt = S_ACK;
            S_ACK:    w_state_nxt = (FLAG_SETTLE == 0) ? S_IDLE : S_SETTLE;
            S_SETTLE: if (w_cnt_inc == LP_SETTLE) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; r_cnt doubles as the settle counter after ACK.
    always_comb begin
        w_g_nxt         = r_g;
        w_rr_nxt        = r_rr;
        w_cnt_nxt       = r_cnt;
        w_ack_nxt       = '0;
        w_resp_err_nxt  = 1'b0;
        w_mem_req_nxt   = 1'b0;
        w_mem_op_nxt    = '0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_srd_nxt       = r_srd;
        w_mrd_nxt       = r_mrd;
        w_err_to_nxt    = r_err_to;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_g_nxt       = w_pick;
                    w_rr_nxt      = w_pick + 2'd1;
                    w_mem_req_nxt = 1'b1;
                    w_mem_op_nxt  = w_pick;
                    if (w_pick == 2'd0) w_mem_wdata_nxt = bus.slave_wdata;
                    if (w_pick == 2'd2) w_mem_wdata_nxt = bus.master_wdata;
                end
            end
            S_ISSUE: w_cnt_nxt = '0;
            S_WAIT: begin
                if (bus.mem_done) begin
                    w_ack_nxt[r_g] = 1'b1;
                    if (r_g == 2'd1) w_srd_nxt = bus.mem_rdata;
                    if (r_g == 2'd3) w_mrd_nxt = bus.mem_rdata;
                end else if (w_timeout) begin
                    w_ack_nxt[r_g] = 1'b1;
                    w_resp_err_nxt = 1'b1;
                    w_err_to_nxt   = 1'b1;
                    if (r_g == 2'd1) w_srd_nxt = '0;
                    if (r_g == 2'd3) w_mrd_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_ACK:    w_cnt_nxt = '0;
            S_SETTLE: w_cnt_nxt = w_cnt_inc;
            default:  w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_g         <= '0;
            r_rr        <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_resp_err  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_op    <= '0;
            r_mem_wdata <= '0;
            r_srd       <= '0;
            r_mrd       <= '0;
            r_err_to    <= 1'b0;
        end else begin
            r_g         <= w_g_nxt;
            r_rr        <= w_rr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ack       <= w_ack_nxt;
            r_resp_err  <= w_resp_err_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_op    <= w_mem_op_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_srd       <= w_srd_nxt;
            r_mrd       <= w_mrd_nxt;
            r_err_to    <= w_err_to_nxt;
        end
    end

    assign bus.ack          = r_ack;
    assign bus.resp_err     = r_resp_err;
    assign bus.slave_rdata  = r_srd;
    assign bus.master_rdata = r_mrd;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_op       = r_mem_op;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.err_timeout  = r_err_to;
endmodule
